cifrador_flujo: RTL
===================

Name: cifrador_flujo

Overview:
Parametrised, clocked successor to the 8-bit combinational cipher. It encrypts or decrypts a stream of WIDTH-bit words by XOR with a keystream from a loadable Galois LFSR, with an optional rotate stage. Words move through valid/ready handshakes with one-cycle latency. It sits between a data source and a sink, and the key is loaded by the controller.

Parameters:
WIDTH, 8, data word width in bits (1..LFSR_W)
LFSR_W, 16, keystream LFSR width
POLY, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
ROT, 1, rotate amount for mode 1 (0..WIDTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
key_load  in  1  one-cycle pulse: load key_in into the LFSR
key_in  in  LFSR_W  key/seed
mode  in  1  0 = XOR only, 1 = XOR plus rotate (sampled with each accepted word)
decrypt  in  1  0 = encrypt, 1 = decrypt (sampled with each accepted word)
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_data  in  WIDTH  plaintext or ciphertext
out_valid  out  1  output register holds a result
out_ready  in  1  sink accepts the result
out_data  out  WIDTH  result
keyed  out  1  a key has been loaded since reset
word_cnt  out  16  words processed since the last key load, wraps at 2^16

Behaviour:
- Reset (async, rst=1): state UNKEYED, lfsr=0, out_valid=0, out_data=0, word_cnt=0, keyed=0. in_ready=0 while rst is high.
- States:
  - UNKEYED: in_ready=0. key_load moves to RUN.
  - RUN: stays in RUN. A further key_load rekeys in place.
- Key load: lfsr <= (key_in==0) ? 1 : key_in, so LFSR lock-up is impossible. word_cnt <= 0. keyed <= 1.
  - An output word already in the register is kept and not flushed.
- in_ready = (state==RUN) && !key_load && (!out_valid || out_ready). Key load has priority, so no word is accepted in a key_load cycle.
- Accept: in_valid && in_ready on a rising edge. Then ks = lfsr[WIDTH-1:0].
  - Encrypt: y = data ^ ks; if mode=1, y = rotl(y, ROT).
  - Decrypt: t = (mode=1) ? rotr(data, ROT) : data; y = t ^ ks.
  - Encrypt followed by decrypt with the same key, mode and word index returns the original word.
- On accept:
  - out_data <= y, out_valid <= 1 (latency 1 cycle).
  - lfsr advances WIDTH Galois steps. One step: lsb = s[0]; s = s>>1; if lsb, s ^= POLY.
  - word_cnt increments, wrapping 0xFFFF -> 0.
- out_valid clears on out_ready when no new accept happens that cycle. With a simultaneous drain and accept, out_valid stays 1 and the register gets the new word (full throughput).
- Backpressure: with out_valid=1 and out_ready=0, out_data/out_valid hold and lfsr does not advance.
- in_data, mode and decrypt are ignored unless accepted.
- Reset mid-stream: the pending output is dropped. The block needs a new key before in_ready rises again.

Decomposition:
- Package cifrador_pkg holds:
  - state enum {UNKEYED, RUN}
  - default POLY/LFSR_W constants
  - pure functions rotl, rotr, lfsr_step
- One sub-module, cifrador_lfsr: holds the state, load/advance-by-WIDTH controls, keystream output.
- The top holds handshake, datapath and counter.

Test Plan:
1. Reset, then in_valid=1 with no key -> in_ready=0, out_valid=0, keyed=0 over 20 cycles.
2. WIDTH=8, key_in=16'h00A5, mode=0, encrypt, in_data=8'h3C -> out_data=8'h99 one cycle later; word_cnt=1. Same key, decrypt 8'h99 -> 8'h3C.
3. mode=1, ROT=1, key 16'h00A5, encrypt 8'h3C -> 8'h33. Decrypt 8'h33 -> 8'h3C.
4. key_in=0, encrypt 8'h00 -> 8'h01 (substituted seed). Stream of 64 words encrypted then decrypted after rekey -> all 64 originals recovered, word_cnt=64.
5. Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> one word held, in_ready=0, lfsr frozen. Release -> the next word's result equals the unstalled reference model.
6. key_load asserted with in_valid=1 -> no accept that cycle, word_cnt=0. rst pulse mid-stream -> out_valid=0 immediately (async), keyed=0.

Source files
------------

// File: rtl/cifrador_pkg.sv
// Shared types and pure helpers for the stream cipher: FSM states, default LFSR
// constants, rotations and a single Galois LFSR step.
package cifrador_pkg;

   typedef enum logic {UNKEYED = 1'b0, RUN = 1'b1} state_t;

   localparam int          LFSR_W_DEF = 16;
   localparam logic [15:0] POLY_DEF   = 16'hB400;

   // Helpers work on a wide container; callers truncate with a size cast.
   localparam int MAX_W = 64;
   typedef logic [MAX_W-1:0] word_t;

   function automatic word_t rotl(word_t x, int w, int r);
      word_t m;
      word_t v;
      m = (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
      v = x & m;
      if (r == 0) return v;
      return ((v << r) | (v >> (w - r))) & m;
   endfunction

   function automatic word_t rotr(word_t x, int w, int r);
      return rotl(x, w, (r == 0) ? 0 : w - r);
   endfunction

   function automatic word_t lfsr_step(word_t s, word_t poly);
      return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
   endfunction

endpackage

// File: rtl/cifrador_lfsr.sv
// Loadable Galois LFSR that advances WIDTH steps per consumed keystream word.
module cifrador_lfsr
   import cifrador_pkg::*;
#(
   parameter int                WIDTH  = 8,
   parameter int                LFSR_W = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(POLY_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              adv,
   output logic [WIDTH-1:0]  ks
);

   logic [LFSR_W-1:0] lfsr, lfsr_nx;

   always_comb begin
      lfsr_nx = lfsr;
      for (int i = 0; i < WIDTH; i++)
         lfsr_nx = LFSR_W'(lfsr_step(word_t'(lfsr_nx), word_t'(POLY)));
   end

   // A zero seed would lock the register at zero forever, so substitute 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= '0;
      else if (load)
         lfsr <= (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
      else if (adv)
         lfsr <= lfsr_nx;
   end

   assign ks = lfsr[WIDTH-1:0];

endmodule

// File: rtl/cifrador_flujo.sv
// Clocked stream cipher: XOR with LFSR keystream plus optional rotate, one-word
// output register behind valid/ready handshakes.
module cifrador_flujo
   import cifrador_pkg::*;
#(
   parameter int                WIDTH  = 8,
   parameter int                LFSR_W = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(POLY_DEF),
   parameter int                ROT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_load,
   input  logic [LFSR_W-1:0] key_in,
   input  logic              mode,
   input  logic              decrypt,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              keyed,
   output logic [15:0]       word_cnt
);

   state_t           state, state_nx;
   logic             accept;
   logic [WIDTH-1:0] ks, y, t;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= UNKEYED;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (key_load) state_nx = RUN;
   end

   // Key load wins over data, so no word is ever encrypted with a stale key.
   always_comb begin
      keyed    = (state == RUN);
      in_ready = (state == RUN) && !key_load && (!out_valid || out_ready);
   end

   assign accept = in_valid && in_ready;

   cifrador_lfsr #(.WIDTH(WIDTH), .LFSR_W(LFSR_W), .POLY(POLY)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (key_load),
      .seed (key_in),
      .adv  (accept),
      .ks   (ks)
   );

   always_comb begin
      t = '0;
      y = '0;
      if (decrypt) begin
         t = mode ? WIDTH'(rotr(word_t'(in_data), WIDTH, ROT)) : in_data;
         y = t ^ ks;
      end else begin
         t = in_data ^ ks;
         y = mode ? WIDTH'(rotl(word_t'(t), WIDTH, ROT)) : t;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         word_cnt  <= '0;
      end else begin
         if (accept) begin
            out_data  <= y;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (key_load)    word_cnt <= '0;
         else if (accept) word_cnt <= word_cnt + 16'd1;
      end
   end

endmodule
